byte_stream_fifo: RTL and testbench
===================================

Name: byte_stream_fifo

Overview:
- Synchronous first-word-fall-through FIFO that sits directly downstream of the 8-bit reset-able data register stage.
- Captures the register's q output on a valid/ready write port and buffers it for a slower or back-pressured consumer.
- Reports occupancy, plus a sticky overflow flag when the producer offers data while the FIFO is full.

Parameters:
- WIDTH, 8, data width in bits; matches the upstream register width.
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- wr_valid  input  1  producer offers wr_data this cycle.
- wr_data  input  WIDTH  data from the upstream register q.
- wr_ready  output  1  FIFO accepts on this edge; equals not full.
- rd_valid  output  1  head entry present; equals not empty.
- rd_data  output  WIDTH  head entry; 0 when empty.
- rd_ready  input  1  consumer takes the head on this edge.
- count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set on an attempted write while full.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low. While reset == 0: write/read pointers = 0, count = 0, overflow = 0, full = 0, empty = 1, wr_ready = 1, rd_valid = 0, rd_data = 0.
  - Storage array is not reset.
  - Deassertion of reset takes effect at the next rising edge.
- Handshake:
  - push = wr_valid & wr_ready; pop = rd_valid & rd_ready.
  - Both are evaluated on the rising edge.
  - wr_ready and rd_valid must not depend combinationally on wr_valid or rd_ready.
- Latency:
  - Data pushed on edge N appears on rd_data/rd_valid immediately after edge N (one-cycle fall-through).
  - There is no same-cycle bypass when empty.
- FWFT read:
  - rd_data is driven combinationally from mem[rd_ptr] when not empty, else 0.
  - Pop advances rd_ptr by 1.
- Pointers:
  - Pointer width is $clog2(DEPTH)+1; the extra MSB is a wrap bit.
  - full when the low bits are equal and the MSBs differ; empty when the pointers are identical.
  - count = wr_ptr - rd_ptr (modular).
- Simultaneous push and pop (not empty, not full): count unchanged, both pointers advance.
- Full boundary:
  - wr_ready = 0, so push is impossible.
  - Pop alone proceeds; wr_ready rises the cycle after that edge.
- Empty boundary:
  - rd_valid = 0, so pop is impossible.
  - Push alone proceeds; rd_valid rises after that edge.
- Wrap-around: pointers wrap modulo 2*DEPTH; FIFO ordering is preserved across the wrap.
- Overflow:
  - Set on an edge where wr_valid = 1 and full = 1.
  - Cleared on an edge where clr_ovf = 1.
  - If both occur on the same edge, set wins.
  - The offered data is dropped; there is no other side effect.
- Reset mid-operation: contents are discarded and the FIFO is empty on the next observation, regardless of pending handshakes.
- Invariant: count never exceeds DEPTH and never underflows. A bench assertion checks this.

Decomposition:
- Package byte_stream_pkg holds:
  - localparam BYTE_W = 8
  - typedef byte_t (logic [BYTE_W-1:0])
  - function ptr_w(depth), returning $clog2(depth)+1
- One natural sub-module, byte_stream_fifo_mem: DEPTH x WIDTH register array with a synchronous write port and a combinational read port. No reset.
- Pointer, count, and flag logic stays in the top module.

Test Plan:
- Reset check: hold reset = 0 for 20 ns with wr_valid = 1, wr_data = 8'hA5 → empty = 1, count = 0, rd_data = 0, overflow = 0 throughout.
- Fill to full: release reset, push 8'h01..8'h08 on consecutive edges with rd_ready = 0 → count steps 1..8; full = 1 and wr_ready = 0 after the 8th edge; rd_data = 8'h01 from the first edge onward.
- Overflow: while full, assert wr_valid with 8'hFF for one edge → overflow = 1, count stays 8, contents unchanged. Then pulse clr_ovf → overflow = 0. Then wr_valid and clr_ovf on the same edge while full → overflow = 1.
- Drain in order: rd_ready = 1 with no writes → rd_data sequence 01..08, one value per edge; empty = 1 and rd_data = 0 after the 8th pop.
- Wrap and concurrency: push and pop simultaneously every edge for 20 edges with 1..3 entries held → count constant; output sequence matches input sequence across pointer wrap (0x00..0x13).
- Reset mid-stream: with count = 5, pulse reset low for 3 ns between edges → count = 0 and empty = 1 immediately. After release, a push of 8'h3C reads back 8'h3C.

Source files
------------

// File: rtl/byte_stream_pkg.sv
// Shared definitions for the byte stream buffer that follows the 8-bit data
// register stage.
//   BYTE_W  : width of the upstream register / default FIFO data width
//   byte_t  : one byte of stream data
//   ptr_w() : pointer width for a given depth (address bits plus a wrap bit)
package byte_stream_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/byte_stream_fifo_mem.sv
// DEPTH x WIDTH storage for byte_stream_fifo. One synchronous write port and
// one combinational read port. The array is deliberately not reset; validity
// of entries is tracked by the pointers in the parent.
//   clk   : write clock
//   we    : write enable, sampled on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
module byte_stream_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/byte_stream_fifo.sv
// First-word-fall-through FIFO buffering the q output of the 8-bit data
// register for a slower or back-pressured consumer.
//   clk      : single clock, rising edge
//   reset    : asynchronous active-low reset
//   wr_valid : producer offers wr_data
//   wr_data  : data from the upstream register
//   wr_ready : FIFO not full; a push happens when wr_valid & wr_ready
//   rd_valid : FIFO not empty; head entry on rd_data
//   rd_data  : head entry, 0 when empty
//   rd_ready : consumer takes the head when rd_valid & rd_ready
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
//   overflow : sticky, set when wr_valid is seen while full
//   clr_ovf  : synchronous clear of overflow (a same-edge set wins)
// DEPTH must be a power of two and at least 2.
module byte_stream_fifo
    import byte_stream_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     rd_ready,
    output logic [ptr_w(DEPTH)-1:0]  count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits coincide.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;

    // Handshake outputs depend only on registered pointers, never on
    // wr_valid or rd_ready.
    assign wr_ready = ~full;
    assign rd_valid = ~empty;

    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    assign rd_data  = empty ? '0 : head;

    byte_stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // The dropped write has no side effect besides this flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (wr_valid && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_stream_fifo.sv
// Directed bench for byte_stream_fifo. Stimulus pushes the expected read
// data into a queue as it offers writes; a negedge monitor pops and compares
// whenever the DUT presents a head that the consumer is taking.
module tb_byte_stream_fifo;
    import byte_stream_pkg::*;

    localparam int DEPTH = 8;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    byte_t      wr_data;
    logic       wr_ready;
    logic       rd_valid;
    byte_t      rd_data;
    logic       rd_ready;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf;

    int    n_checks = 0;
    int    n_errors = 0;
    byte_t exp_q[$];

    byte_stream_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge and settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a pop happens on the coming edge whenever the head
    // is valid and the consumer is ready.
    always @(negedge clk) begin
        if (reset && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got %0h, expected no data at %0t", rd_data, $time);
            end else begin
                chk("sb_data", rd_data, exp_q.pop_front());
            end
        end
    end

    // Occupancy invariant.
    always @(negedge clk) begin
        assert (count <= 4'(DEPTH))
        else begin
            n_errors++;
            $display("FAIL count_range: got %0d, expected <= %0d", count, DEPTH);
        end
    end

    initial begin
        reset    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;

        // Reset held with a write offered.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_empty", empty, 1);
            chk("rst_count", count, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_wr_ready", wr_ready, 1);
        end
        #1;
        reset    = 1'b1;
        wr_valid = 1'b0;

        // Fill to full.
        for (int i = 1; i <= DEPTH; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            exp_q.push_back(8'(i));
            step();
            chk("fill_count", count, i);
            chk("fill_head", rd_data, 8'h01);
            chk("fill_full", full, (i == DEPTH) ? 1 : 0);
            chk("fill_wr_ready", wr_ready, (i == DEPTH) ? 0 : 1);
        end
        wr_valid = 1'b0;

        // Overflow set, clear, and set-wins-over-clear.
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        step();
        wr_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, DEPTH);
        chk("ovf_head", rd_data, 8'h01);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);
        wr_valid = 1'b1;
        clr_ovf  = 1'b1;
        step();
        wr_valid = 1'b0;
        clr_ovf  = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        chk("ovf_count2", count, DEPTH);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr2", overflow, 0);

        // Drain in order; data checked by the monitor.
        rd_ready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("drain_count", count, DEPTH - k);
        end
        rd_ready = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_rd_data", rd_data, 0);
        chk("drain_rd_valid", rd_valid, 0);

        // Concurrent push/pop across the pointer wrap, two entries held.
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            exp_q.push_back(8'(i));
            step();
        end
        chk("wrap_prefill", count, 2);
        rd_ready = 1'b1;
        for (int i = 2; i < 20; i++) begin
            wr_data = 8'(i);
            exp_q.push_back(8'(i));
            step();
            chk("wrap_count", count, 2);
        end
        wr_valid = 1'b0;
        step();
        chk("wrap_tail1", count, 1);
        step();
        chk("wrap_tail0", count, 0);
        rd_ready = 1'b0;
        chk("wrap_empty", empty, 1);

        // Reset in the middle of a stream.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h50 + i);
            exp_q.push_back(8'(8'h50 + i));
            step();
        end
        wr_valid = 1'b0;
        chk("mid_count5", count, 5);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_rd_data", rd_data, 0);
        #2;
        reset = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        exp_q.push_back(8'h3C);
        step();
        wr_valid = 1'b0;
        chk("post_rst_count", count, 1);
        chk("post_rst_head", rd_data, 8'h3C);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("post_rst_empty", empty, 1);

        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
